// File: rtl/note_judge.sv
// Per-lane rhythm-game hit judge: synchronises buttons, runs an IDLE/ARMED/JUDGED FSM per lane,
// and emits registered noteAction/noteSuccessState plus saturating hit/miss/combo statistics.
module note_judge #(
    parameter int CNT_W            = 16,
    parameter bit EMPTY_PRESS_MISS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gameActive,
    input  logic             clearStats,
    input  logic [3:0]       buttons,
    input  logic [3:0]       noteWindow,
    output logic [3:0]       noteAction,
    output logic [3:0]       noteSuccessState,
    output logic [CNT_W-1:0] hitCount,
    output logic [CNT_W-1:0] missCount,
    output logic [CNT_W-1:0] combo,
    output logic [CNT_W-1:0] maxCombo
);

    typedef enum logic [1:0] {IDLE, ARMED, JUDGED} lane_state_t;

    logic [3:0]       r_s1, r_s2, r_s3;
    logic [3:0]       w_press;
    logic [3:0]       w_hit, w_miss;
    logic [3:0]       r_action, r_success;
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt, r_combo, r_max_combo;
    logic [2:0]       w_h, w_m;
    logic [CNT_W-1:0] w_combo_next;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Increments are at most 4, so the carry bit alone flags overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Synchronisers keep running while the game is paused so re-enabling sees no false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 4'b0;
            r_s2 <= 4'b0;
            r_s3 <= 4'b0;
        end else begin
            r_s1 <= buttons;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_press = r_s2 & ~r_s3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            lane_state_t r_state, w_state_next;
            logic        w_lane_hit, w_lane_miss;

            always_comb begin
                w_state_next = r_state;
                w_lane_hit   = 1'b0;
                w_lane_miss  = 1'b0;
                if (!gameActive) begin
                    w_state_next = IDLE;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (noteWindow[gi] && w_press[gi]) begin
                                w_lane_hit   = 1'b1;
                                w_state_next = JUDGED;
                            end else if (noteWindow[gi]) begin
                                w_state_next = ARMED;
                            end else if (w_press[gi] && EMPTY_PRESS_MISS) begin
                                w_lane_miss = 1'b1;
                            end
                        end
                        ARMED: begin
                            // A press in the same cycle as the window closing still counts as a hit.
                            if (w_press[gi]) begin
                                w_lane_hit   = 1'b1;
                                w_state_next = JUDGED;
                            end else if (!noteWindow[gi]) begin
                                w_lane_miss  = 1'b1;
                                w_state_next = IDLE;
                            end
                        end
                        JUDGED: begin
                            if (!noteWindow[gi]) w_state_next = IDLE;
                        end
                        default: w_state_next = IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) r_state <= IDLE;
                else     r_state <= w_state_next;
            end

            assign w_hit[gi]  = w_lane_hit;
            assign w_miss[gi] = w_lane_miss;
        end
    endgenerate

    assign w_h = popcount4(w_hit);
    assign w_m = popcount4(w_miss);
    assign w_combo_next = (w_m != 3'd0) ? {CNT_W{1'b0}} : sat_add(r_combo, w_h);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_action    <= 4'b0;
            r_success   <= 4'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_combo     <= '0;
            r_max_combo <= '0;
        end else begin
            r_action  <= w_hit | w_miss;
            r_success <= (r_success & ~(w_hit | w_miss)) | w_hit;
            if (clearStats) begin
                r_hit_cnt   <= '0;
                r_miss_cnt  <= '0;
                r_combo     <= '0;
                r_max_combo <= '0;
            end else begin
                r_hit_cnt   <= sat_add(r_hit_cnt, w_h);
                r_miss_cnt  <= sat_add(r_miss_cnt, w_m);
                r_combo     <= w_combo_next;
                r_max_combo <= (w_combo_next > r_max_combo) ? w_combo_next : r_max_combo;
            end
        end
    end

    assign noteAction       = r_action;
    assign noteSuccessState = r_success;
    assign hitCount         = r_hit_cnt;
    assign missCount        = r_miss_cnt;
    assign combo            = r_combo;
    assign maxCombo         = r_max_combo;

endmodule

// File: tb/tb_note_judge.sv
// Directed bench for note_judge: two instances (empty press ignored / judged a miss), CNT_W=4,
// shared stimulus, immediate assertions against hand-computed values.
module tb_note_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gameActive = 1'b1;
    logic       clearStats = 1'b0;
    logic [3:0] buttons = 4'b0;
    logic [3:0] noteWindow = 4'b0;

    logic [3:0] noteAction, noteSuccessState;
    logic [3:0] hitCount, missCount, combo, maxCombo;
    logic [3:0] e_action, e_success;
    logic [3:0] e_hit, e_miss, e_combo, e_max;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    note_judge #(.CNT_W(4), .EMPTY_PRESS_MISS(1'b0)) dut (
        .clk(clk), .rst(rst), .gameActive(gameActive), .clearStats(clearStats),
        .buttons(buttons), .noteWindow(noteWindow),
        .noteAction(noteAction), .noteSuccessState(noteSuccessState),
        .hitCount(hitCount), .missCount(missCount), .combo(combo), .maxCombo(maxCombo)
    );

    note_judge #(.CNT_W(4), .EMPTY_PRESS_MISS(1'b1)) dut_e (
        .clk(clk), .rst(rst), .gameActive(gameActive), .clearStats(clearStats),
        .buttons(buttons), .noteWindow(noteWindow),
        .noteAction(e_action), .noteSuccessState(e_success),
        .hitCount(e_hit), .missCount(e_miss), .combo(e_combo), .maxCombo(e_max)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst_action",  {12'b0, noteAction}, 16'h0);
        chk("rst_success", {12'b0, noteSuccessState}, 16'h0);
        chk("rst_hit",     {12'b0, hitCount}, 16'h0);
        chk("rst_miss",    {12'b0, missCount}, 16'h0);
        chk("rst_combo",   {12'b0, combo}, 16'h0);
        chk("rst_max",     {12'b0, maxCombo}, 16'h0);
        rst = 1'b0;

        // Hit timing on lane 3
        noteWindow = 4'b1000;
        repeat (4) tick();
        buttons = 4'b1000;
        tick(); tick();
        chk("hit_early", {12'b0, noteAction}, 16'h0);
        tick();
        chk("hit_pulse",   {12'b0, noteAction}, 16'h8);
        chk("hit_success", {12'b0, noteSuccessState}, 16'h8);
        chk("hit_count",   {12'b0, hitCount}, 16'h1);
        chk("hit_combo",   {12'b0, combo}, 16'h1);
        chk("hit_max",     {12'b0, maxCombo}, 16'h1);
        tick();
        chk("hit_one_cycle", {12'b0, noteAction}, 16'h0);
        buttons = 4'b0; noteWindow = 4'b0;
        tick(); tick();

        // Miss on lane 0
        noteWindow = 4'b0001;
        repeat (10) tick();
        chk("miss_armed_quiet", {12'b0, noteAction}, 16'h0);
        noteWindow = 4'b0000;
        tick();
        chk("miss_pulse",   {12'b0, noteAction}, 16'h1);
        chk("miss_success", {12'b0, noteSuccessState}, 16'h8);
        chk("miss_count",   {12'b0, missCount}, 16'h1);
        chk("miss_combo",   {12'b0, combo}, 16'h0);
        chk("miss_max",     {12'b0, maxCombo}, 16'h1);
        tick();

        // Button held before the window opens on lane 1
        buttons = 4'b0010;
        repeat (4) tick();
        noteWindow = 4'b0010;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (noteAction != 4'b0) pulses++;
        end
        chk("held_no_pulse", pulses[15:0], 16'h0);
        noteWindow = 4'b0000;
        tick();
        chk("held_miss_pulse", {12'b0, noteAction}, 16'h2);
        chk("held_miss_count", {12'b0, missCount}, 16'h2);
        chk("held_hit_count",  {12'b0, hitCount}, 16'h1);
        buttons = 4'b0;
        repeat (3) tick();

        // Double press on lane 2
        noteWindow = 4'b0100;
        tick();
        buttons = 4'b0100;
        tick(); tick(); tick();
        chk("dbl_first_pulse", {12'b0, noteAction}, 16'h4);
        buttons = 4'b0;
        tick(); tick();
        buttons = 4'b0100;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (noteAction != 4'b0) pulses++;
        end
        chk("dbl_second_ignored", pulses[15:0], 16'h0);
        chk("dbl_hit_count", {12'b0, hitCount}, 16'h2);
        chk("dbl_combo",     {12'b0, combo}, 16'h1);
        noteWindow = 4'b0; buttons = 4'b0;
        repeat (3) tick();

        // All four lanes hit together
        noteWindow = 4'b1111;
        tick();
        buttons = 4'b1111;
        tick(); tick(); tick();
        chk("all_pulse", {12'b0, noteAction}, 16'hF);
        chk("all_hit",   {12'b0, hitCount}, 16'h6);
        chk("all_combo", {12'b0, combo}, 16'h5);
        chk("all_max",   {12'b0, maxCombo}, 16'h5);
        buttons = 4'b0; noteWindow = 4'b0;
        tick(); tick();

        // Lanes 0,1 hit while 2,3 miss on the same edge
        noteWindow = 4'b1111;
        tick();
        buttons = 4'b0011;
        tick(); tick();
        noteWindow = 4'b0000;
        tick();
        chk("mix_pulse",   {12'b0, noteAction}, 16'hF);
        chk("mix_success", {12'b0, noteSuccessState}, 16'h3);
        chk("mix_hit",     {12'b0, hitCount}, 16'h8);
        chk("mix_miss",    {12'b0, missCount}, 16'h4);
        chk("mix_combo",   {12'b0, combo}, 16'h0);
        chk("mix_max",     {12'b0, maxCombo}, 16'h5);
        buttons = 4'b0;
        repeat (3) tick();

        // 17 more hits on lane 0: counters saturate at 15
        for (int n = 0; n < 17; n++) begin
            noteWindow = 4'b0001;
            tick();
            buttons = 4'b0001;
            tick(); tick(); tick();
            buttons = 4'b0; noteWindow = 4'b0;
            tick(); tick();
        end
        chk("sat_hit",   {12'b0, hitCount}, 16'hF);
        chk("sat_combo", {12'b0, combo}, 16'hF);
        chk("sat_max",   {12'b0, maxCombo}, 16'hF);
        chk("sat_miss",  {12'b0, missCount}, 16'h4);

        // clearStats coincident with a hit on lane 1
        noteWindow = 4'b0010;
        tick();
        buttons = 4'b0010;
        tick(); tick();
        clearStats = 1'b1;
        tick();
        clearStats = 1'b0;
        chk("clr_pulse",   {12'b0, noteAction}, 16'h2);
        chk("clr_success", {12'b0, noteSuccessState}, 16'h3);
        chk("clr_hit",     {12'b0, hitCount}, 16'h0);
        chk("clr_miss",    {12'b0, missCount}, 16'h0);
        chk("clr_combo",   {12'b0, combo}, 16'h0);
        chk("clr_max",     {12'b0, maxCombo}, 16'h0);
        buttons = 4'b0; noteWindow = 4'b0;
        tick(); tick();

        // gameActive dropped while lane 2 is armed
        noteWindow = 4'b0100;
        tick(); tick();
        gameActive = 1'b0;
        pulses = 0;
        tick();
        if (noteAction != 4'b0) pulses++;
        noteWindow = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (noteAction != 4'b0) pulses++;
        end
        gameActive = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (noteAction != 4'b0) pulses++;
        end
        chk("pause_no_pulse", pulses[15:0], 16'h0);
        chk("pause_miss",     {12'b0, missCount}, 16'h0);
        chk("pause_success",  {12'b0, noteSuccessState}, 16'h3);

        // Empty press after a fresh reset: only the EMPTY_PRESS_MISS instance judges it
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_success", {12'b0, noteSuccessState}, 16'h0);
        buttons = 4'b1000;
        tick(); tick(); tick();
        chk("empty_pulse_off", {12'b0, noteAction}, 16'h0);
        chk("empty_pulse_on",  {12'b0, e_action}, 16'h8);
        chk("empty_miss_off",  {12'b0, missCount}, 16'h0);
        chk("empty_miss_on",   {12'b0, e_miss}, 16'h1);
        chk("empty_success_on", {12'b0, e_success}, 16'h0);
        buttons = 4'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
